// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: single-outstanding CPU access against a word-wide dmem.
// Define DMEM_LSU_SUBWORD_EN to enable byte/half accesses (read-modify-write for sub-word stores).
module dmem_lsu #(
  parameter int WORD_ADDR_W = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic                   reqWrite,
  input  logic [1:0]             reqSize,
  input  logic                   reqSigned,
  input  logic [WORD_ADDR_W+1:0] reqAddr,
  input  logic [31:0]            reqWdata,
  output logic                   respValid,
  input  logic                   respReady,
  output logic [31:0]            respRdata,
  output logic                   respErr,
  output logic [WORD_ADDR_W-1:0] memReadAddress,
  input  logic [31:0]            memReadData,
  output logic [WORD_ADDR_W-1:0] memWriteAddress,
  output logic [31:0]            memWriteData,
  output logic                   memWriteEn
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef DMEM_LSU_SUBWORD_EN
    RMW_RD,
`endif
    WRITE,
    RESP
  } state_t;

  state_t                 state;
  logic                   reqLegal;
  logic [WORD_ADDR_W-1:0] reqWordIdx;
  logic [31:0]            loadVal;

`ifdef DMEM_LSU_SUBWORD_EN
  logic [1:0]  rSize;
  logic        rSigned;
  logic [1:0]  rLane;
  logic [15:0] rWdata;
  logic [31:0] laneData;
  logic [31:0] mergedWord;
`else
  logic unusedSink;
  assign unusedSink = reqSigned;
`endif

  assign reqReady   = (state == IDLE);
  assign reqWordIdx = reqAddr[WORD_ADDR_W+1:2];

  always_comb begin
`ifdef DMEM_LSU_SUBWORD_EN
    case (reqSize)
      2'b00:   reqLegal = 1'b1;
      2'b01:   reqLegal = ~reqAddr[0];
      2'b10:   reqLegal = (reqAddr[1:0] == 2'b00);
      default: reqLegal = 1'b0;
    endcase
`else
    reqLegal = (reqSize == 2'b10) && (reqAddr[1:0] == 2'b00);
`endif
  end

`ifdef DMEM_LSU_SUBWORD_EN
  // Shared lane extraction for loads and lane insertion for read-modify-write stores.
  always_comb begin
    laneData = memReadData >> {rLane, 3'b000};
    case (rSize)
      2'b00:   loadVal = {{24{rSigned & laneData[7]}}, laneData[7:0]};
      2'b01:   loadVal = {{16{rSigned & laneData[15]}}, laneData[15:0]};
      default: loadVal = memReadData;
    endcase
    mergedWord = memReadData;
    if (rSize == 2'b00) mergedWord[{rLane, 3'b000} +: 8] = rWdata[7:0];
    else                mergedWord[{rLane[1], 4'b0000} +: 16] = rWdata;
  end
`else
  assign loadVal = memReadData;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      respValid       <= 1'b0;
      respRdata       <= '0;
      respErr         <= 1'b0;
      memReadAddress  <= '0;
      memWriteAddress <= '0;
      memWriteData    <= '0;
      memWriteEn      <= 1'b0;
`ifdef DMEM_LSU_SUBWORD_EN
      rSize           <= '0;
      rSigned         <= 1'b0;
      rLane           <= '0;
      rWdata          <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (reqValid) begin
          memReadAddress <= reqWordIdx;
`ifdef DMEM_LSU_SUBWORD_EN
          rSize   <= reqSize;
          rSigned <= reqSigned;
          rLane   <= reqAddr[1:0];
          rWdata  <= reqWdata[15:0];
`endif
          if (!reqLegal) begin
            state     <= RESP;
            respValid <= 1'b1;
            respErr   <= 1'b1;
            respRdata <= '0;
          end else if (!reqWrite) begin
            state <= LOAD;
`ifdef DMEM_LSU_SUBWORD_EN
          end else if (reqSize != 2'b10) begin
            state           <= RMW_RD;
            memWriteAddress <= reqWordIdx;
`endif
          end else begin
            state           <= WRITE;
            memWriteEn      <= 1'b1;
            memWriteAddress <= reqWordIdx;
            memWriteData    <= reqWdata;
          end
        end
        LOAD: begin
          state     <= RESP;
          respValid <= 1'b1;
          respErr   <= 1'b0;
          respRdata <= loadVal;
        end
`ifdef DMEM_LSU_SUBWORD_EN
        RMW_RD: begin
          state        <= WRITE;
          memWriteEn   <= 1'b1;
          memWriteData <= mergedWord;
        end
`endif
        WRITE: begin
          state      <= RESP;
          memWriteEn <= 1'b0;
          respValid  <= 1'b1;
          respErr    <= 1'b0;
          respRdata  <= '0;
        end
        RESP: if (respReady) begin
          state     <= IDLE;
          respValid <= 1'b0;
          respErr   <= 1'b0;
          respRdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed scenarios plus randomized accesses checked against a
// byte-mask reference model of the dmem contents and expected handshake latency.
module tb_dmem_lsu;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
`ifdef DMEM_LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
  localparam logic [31:0] REQ038_WORD = 32'h1122AB44;
`else
  localparam bit SUBWORD = 1'b0;
  localparam logic [31:0] REQ038_WORD = 32'h11223344;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reqValid, reqReady, reqWrite, reqSigned;
  logic [1:0]    reqSize;
  logic [AW+1:0] reqAddr;
  logic [31:0]   reqWdata;
  logic          respValid, respReady, respErr;
  logic [31:0]   respRdata;
  logic [AW-1:0] memReadAddress, memWriteAddress;
  logic [31:0]   memReadData, memWriteData;
  logic          memWriteEn;

  logic [31:0]   dmem   [DEPTH];
  logic [31:0]   refMem [DEPTH];
  logic          tbWrEn = 1'b0;
  logic [AW-1:0] tbWrAddr = '0;
  logic [31:0]   tbWrData = '0;
  int            writePulses = 0;
  int            checksTotal = 0;
  int            checksPassed = 0;

  dmem_lsu #(.WORD_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqSize(reqSize),
    .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
    .respValid(respValid), .respReady(respReady), .respRdata(respRdata), .respErr(respErr),
    .memReadAddress(memReadAddress), .memReadData(memReadData),
    .memWriteAddress(memWriteAddress), .memWriteData(memWriteData), .memWriteEn(memWriteEn)
  );

  always #5 clk = ~clk;

  assign memReadData = dmem[memReadAddress];

  always @(posedge clk) begin
    if (memWriteEn) begin
      dmem[memWriteAddress] <= memWriteData;
      writePulses <= writePulses + 1;
    end
    if (tbWrEn) dmem[tbWrAddr] <= tbWrData;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checksTotal++;
    if (got === exp) checksPassed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic pokeWord(input int idx, input logic [31:0] data);
    @(negedge clk);
    tbWrEn   = 1'b1;
    tbWrAddr = AW'(idx);
    tbWrData = data;
    refMem[idx] = data;
    @(posedge clk);
    #1 tbWrEn = 1'b0;
  endtask

  // Reference: access legality, extended load value, and memory update from byte masks.
  task automatic model(input logic w, input logic [1:0] sz, input logic sgn,
                       input logic [AW+1:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd,
                       output int lat, output int writes);
    int idx, lane, nbytes;
    logic [31:0] mask, val;
    idx    = int'(addr[AW+1:2]);
    lane   = int'(addr[1:0]);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    err    = (nbytes == 0) || (lane % nbytes != 0) || (!SUBWORD && nbytes != 4);
    rd     = '0;
    lat    = 1;
    writes = 0;
    if (!err) begin
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      if (!w) begin
        val = (refMem[idx] >> (8 * lane)) & mask;
        if (sgn && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        rd  = val;
        lat = 2;
      end else begin
        refMem[idx] = (refMem[idx] & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
        writes = 1;
        lat    = (nbytes == 4) ? 2 : 3;
      end
    end
  endtask

  task automatic doAccess(input logic w, input logic [1:0] sz, input logic sgn,
                          input logic [AW+1:0] addr, input logic [31:0] wd, input int holdCycles);
    logic        expErr;
    logic [31:0] expData, heldData;
    int          expLat, expWrites, lat, pulsesBefore;
    model(w, sz, sgn, addr, wd, expErr, expData, expLat, expWrites);
    @(negedge clk);
    checkVal("reqReady_idle", 32'(reqReady), 32'd1);
    pulsesBefore = writePulses;
    reqValid  = 1'b1;
    reqWrite  = w;
    reqSize   = sz;
    reqSigned = sgn;
    reqAddr   = addr;
    reqWdata  = wd;
    @(posedge clk);
    #1;
    reqValid  = 1'b0;
    reqWrite  = 1'($urandom);
    reqSize   = 2'($urandom);
    reqSigned = 1'($urandom);
    reqAddr   = (AW+2)'($urandom);
    reqWdata  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!respValid && lat < 12);
    checkVal("latency", 32'(lat), 32'(expLat));
    checkVal("respErr", 32'(respErr), 32'(expErr));
    checkVal("respRdata", respRdata, expData);
    checkVal("reqReady_busy", 32'(reqReady), 32'd0);
    heldData = respRdata;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkVal("hold_valid", 32'(respValid), 32'd1);
      checkVal("hold_rdata", respRdata, heldData);
      checkVal("hold_ready", 32'(reqReady), 32'd0);
    end
    respReady = 1'b1;
    @(posedge clk);
    #1 respReady = 1'b0;
    @(negedge clk);
    checkVal("resp_dropped", 32'(respValid), 32'd0);
    checkVal("ready_back", 32'(reqReady), 32'd1);
    checkVal("write_pulses", 32'(writePulses - pulsesBefore), 32'(expWrites));
    if (w) checkVal("dmem_word", dmem[addr[AW+1:2]], refMem[addr[AW+1:2]]);
  endtask

  initial begin
    int          pulsesBefore;
    logic [31:0] savedWord;
    rst_n     = 1'b1;
    reqValid  = 1'b0;
    reqWrite  = 1'b0;
    reqSize   = '0;
    reqSigned = 1'b0;
    reqAddr   = '0;
    reqWdata  = '0;
    respReady = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checkVal("rst_respValid", 32'(respValid), 32'd0);
    checkVal("rst_respRdata", respRdata, 32'd0);
    checkVal("rst_respErr", 32'(respErr), 32'd0);
    checkVal("rst_memWriteEn", 32'(memWriteEn), 32'd0);
    checkVal("rst_memReadAddress", 32'(memReadAddress), 32'd0);
    checkVal("rst_memWriteAddress", 32'(memWriteAddress), 32'd0);
    checkVal("rst_memWriteData", memWriteData, 32'd0);
    for (int i = 0; i < 32; i++) pokeWord(i, $urandom);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("ready_after_reset", 32'(reqReady), 32'd1);

    // Word store then word load at word 10
    doAccess(1'b1, 2'b10, 1'b0, 11'h028, 32'd12345, 0);
    checkVal("req036_dmem10", dmem[10], 32'd12345);
    doAccess(1'b0, 2'b10, 1'b0, 11'h028, 32'd0, 1);

    // Sign/zero extension of narrow loads
    pokeWord(11, 32'h000080FF);
    doAccess(1'b0, 2'b00, 1'b1, 11'h02C, 32'd0, 0);
    doAccess(1'b0, 2'b00, 1'b0, 11'h02C, 32'd0, 0);
    doAccess(1'b0, 2'b01, 1'b1, 11'h02E, 32'd0, 0);
    doAccess(1'b0, 2'b01, 1'b1, 11'h02C, 32'd0, 0);

    // Byte store merge
    pokeWord(11, 32'h11223344);
    doAccess(1'b1, 2'b00, 1'b0, 11'h02D, 32'hFFFF_FFAB, 2);
    checkVal("req038_dmem11", dmem[11], REQ038_WORD);

    // Misaligned accesses
    doAccess(1'b0, 2'b01, 1'b0, 11'h029, 32'd0, 0);
    doAccess(1'b1, 2'b10, 1'b0, 11'h02A, 32'hDEAD_BEEF, 0);
    doAccess(1'b0, 2'b11, 1'b0, 11'h028, 32'd0, 0);

    // Response backpressure
    doAccess(1'b0, 2'b10, 1'b0, 11'h028, 32'd0, 5);

    // Reset while the write is being presented
    pulsesBefore = writePulses;
    savedWord    = refMem[12];
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqSize  = 2'b10;
    reqAddr  = 11'h030;
    reqWdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 reqValid = 1'b0;
    checkVal("write_en_in_write", 32'(memWriteEn), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkVal("abort_memWriteEn", 32'(memWriteEn), 32'd0);
    checkVal("abort_respValid", 32'(respValid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("abort_ready", 32'(reqReady), 32'd1);
    checkVal("abort_no_resp", 32'(respValid), 32'd0);
    checkVal("abort_pulses", 32'(writePulses - pulsesBefore), 32'd0);
    checkVal("abort_dmem12", dmem[12], savedWord);

    for (int n = 0; n < 80; n++) begin
      doAccess(1'($urandom), 2'($urandom), 1'($urandom), (AW+2)'($urandom_range(0, 127)),
               $urandom, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
